// File: rtl/spi_master.sv
// SPI master: drives CS/sclk/MOSI from the system clock and captures MISO into a read-back word.
// Build option SPI_MASTER_LSB_FIRST_EN switches both directions to LSB-first ordering.
module spi_master #(
   parameter int DATA_W  = 4,
   parameter int CLK_DIV = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              done,
   output logic              CS,
   output logic              sclk,
   output logic              MOSI,
   input  logic              MISO
);

   localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} state_e;

   state_e            state_q;
   logic [PH_W-1:0]   phase_q;
   logic [BIT_W-1:0]  bit_q;
   logic [DATA_W-1:0] tx_q;
   logic [DATA_W-1:0] rx_q;
   logic [DATA_W-1:0] rx_data_q;
   logic              busy_q;
   logic              done_q;
   logic              cs_q;
   logic              sclk_q;
   logic              mosi_q;

   logic [DATA_W-1:0] tx_d;
   logic [DATA_W-1:0] rx_d;
   logic              first_bit;
   logic              next_bit;
   logic              phase_last;

`ifdef SPI_MASTER_LSB_FIRST_EN
   assign first_bit = tx_data[0];
   assign tx_d      = tx_q >> 1;
   assign next_bit  = tx_d[0];
   assign rx_d      = (rx_q >> 1) | (DATA_W'(MISO) << (DATA_W - 1));
`else
   assign first_bit = tx_data[DATA_W-1];
   assign tx_d      = tx_q << 1;
   assign next_bit  = tx_d[DATA_W-1];
   assign rx_d      = (rx_q << 1) | DATA_W'(MISO);
`endif

   assign phase_last = (phase_q == PH_LAST);

   // Each of LOW, HIGH and HOLD lasts CLK_DIV clocks; MISO is taken as sclk falls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         bit_q     <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cs_q      <= 1'b1;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  tx_q    <= tx_data;
                  mosi_q  <= first_bit;
                  cs_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  phase_q <= '0;
                  bit_q   <= '0;
                  state_q <= LOW;
               end
            end
            LOW: begin
               if (phase_last) begin
                  phase_q <= '0;
                  sclk_q  <= 1'b1;
                  state_q <= HIGH;
               end else begin
                  phase_q <= phase_q + PH_W'(1);
               end
            end
            HIGH: begin
               if (phase_last) begin
                  phase_q <= '0;
                  rx_q    <= rx_d;
                  sclk_q  <= 1'b0;
                  if (bit_q == BIT_LAST) begin
                     mosi_q  <= 1'b0;
                     state_q <= HOLD;
                  end else begin
                     bit_q   <= bit_q + BIT_W'(1);
                     tx_q    <= tx_d;
                     mosi_q  <= next_bit;
                     state_q <= LOW;
                  end
               end else begin
                  phase_q <= phase_q + PH_W'(1);
               end
            end
            HOLD: begin
               if (phase_last) begin
                  phase_q   <= '0;
                  cs_q      <= 1'b1;
                  rx_data_q <= rx_q;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  phase_q <= phase_q + PH_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_data = rx_data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign CS      = cs_q;
   assign sclk    = sclk_q;
   assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: directed table, mid-transfer disturbance, random transfers against a
// word-level model, back-to-back start, and reset during a transfer.
module tb_spi_master;

   localparam int DW  = 4;
   localparam int CD  = 2;
   localparam int LAT = (2 * DW + 1) * CD;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] tx_data;
   logic [DW-1:0] rx_data;
   logic          busy;
   logic          done;
   logic          CS;
   logic          sclk;
   logic          MOSI;
   logic          MISO;

   logic          use_slave;
   logic [DW-1:0] leds;
   logic          slave_miso;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_master #(.DATA_W(DW), .CLK_DIV(CD)) dut (
      .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .rx_data(rx_data),
      .busy(busy), .done(done), .CS(CS), .sclk(sclk), .MOSI(MOSI), .MISO(MISO)
   );

   // Shift-register slave: captures MOSI on rising sclk, presents its newest bit after the fall.
   always @(posedge sclk or posedge rst)
      if (rst) leds <= '0;
      else if (!CS) leds <= {leds[DW-2:0], MOSI};

   always @(negedge sclk or posedge rst)
      if (rst) slave_miso <= 1'b0;
      else if (!CS) slave_miso <= leds[0];

   assign MISO = use_slave ? slave_miso : MOSI;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] reverse(input logic [DW-1:0] w);
      logic [DW-1:0] r;
      for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
      return r;
   endfunction

   // Wire order of a word: first bit on the wire at [DW-1].
   function automatic logic [DW-1:0] wire_order(input logic [DW-1:0] tx);
`ifdef SPI_MASTER_LSB_FIRST_EN
      return reverse(tx);
`else
      return tx;
`endif
   endfunction

   // Samples seen on MISO (first at [DW-1]) assembled into the received word.
   function automatic logic [DW-1:0] model_rx(input logic [DW-1:0] tx, input logic slv,
                                              input logic prior);
      logic [DW-1:0] seq;
      logic [DW-1:0] smp;
      seq = wire_order(tx);
      smp = slv ? {prior, seq[DW-1:1]} : seq;
`ifdef SPI_MASTER_LSB_FIRST_EN
      return reverse(smp);
`else
      return smp;
`endif
   endfunction

   task automatic run_and_check(input string tag, input logic [DW-1:0] tx, input logic slv,
                                input logic disturb, input logic [DW-1:0] alt,
                                input logic [DW-1:0] exp_rx, input logic [DW-1:0] exp_mosi);
      int            k;
      int            rises;
      int            cs_bad;
      int            busy_drop;
      logic          prev;
      logic [DW-1:0] mw;
      @(negedge clk);
      use_slave = slv;
      tx_data   = tx;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check($sformatf("%s_accept_busy", tag), busy, 1'b1);
      check($sformatf("%s_accept_cs", tag), CS, 1'b0);
      k = 0; rises = 0; cs_bad = 0; busy_drop = 0; mw = '0; prev = sclk;
      while (done !== 1'b1 && k < LAT + 20) begin
         if (disturb && k == 3) begin
            start   = 1'b1;
            tx_data = alt;
         end
         if (disturb && k == 9) start = 1'b0;
         @(posedge clk);
         @(negedge clk);
         k++;
         if (sclk && !prev) begin
            rises++;
            mw = {mw[DW-2:0], MOSI};
            if (CS) cs_bad++;
         end
         prev = sclk;
         if (!done && !busy) busy_drop++;
      end
      check($sformatf("%s_latency", tag), k, LAT);
      check($sformatf("%s_rx", tag), rx_data, exp_rx);
      check($sformatf("%s_mosi_seq", tag), mw, exp_mosi);
      check($sformatf("%s_sclk_rises", tag), rises, DW);
      check($sformatf("%s_sclk_while_cs_high", tag), cs_bad, 0);
      check($sformatf("%s_busy_drop", tag), busy_drop, 0);
      check($sformatf("%s_slave_leds", tag), leds, exp_mosi);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_done_width", tag), done, 1'b0);
      check($sformatf("%s_idle_cs", tag), CS, 1'b1);
      check($sformatf("%s_idle_busy", tag), busy, 1'b0);
   endtask

   typedef struct {
      logic [DW-1:0] tx;
      logic          slv;
      logic [DW-1:0] exp_rx;
      logic [DW-1:0] exp_mosi;
   } vec_t;

   vec_t vecs[4];

   initial begin
      logic          prior;
      logic [DW-1:0] tx;
      logic          slv;
      int            dq[$];
      int            runs[$];
      int            cyc;
      int            run;
      int            rises;
      int            dones;
      int            cs_low;
      logic          ps;

`ifdef SPI_MASTER_LSB_FIRST_EN
      vecs[0] = '{4'b0110, 1'b1, 4'b1100, 4'b0110};
      vecs[1] = '{4'b1011, 1'b0, 4'b1011, 4'b1101};
      vecs[2] = '{4'b0001, 1'b0, 4'b0001, 4'b1000};
      vecs[3] = '{4'b1110, 1'b0, 4'b1110, 4'b0111};
`else
      vecs[0] = '{4'b0110, 1'b1, 4'b0011, 4'b0110};
      vecs[1] = '{4'b1011, 1'b0, 4'b1011, 4'b1011};
      vecs[2] = '{4'b0001, 1'b0, 4'b0001, 4'b0001};
      vecs[3] = '{4'b1110, 1'b0, 4'b1110, 4'b1110};
`endif

      rst = 1'b1; start = 1'b0; tx_data = '0; use_slave = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cs", CS, 1'b1);
      check("rst_sclk", sclk, 1'b0);
      check("rst_mosi", MOSI, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rx", rx_data, '0);
      @(negedge clk);
      rst = 1'b0;

      // First entry uses the slave straight after reset, so its MISO starts at 0.
      prior = 1'b0;
      for (int i = 0; i < 4; i++) begin
         run_and_check($sformatf("vec%0d", i), vecs[i].tx, vecs[i].slv, 1'b0, '0,
                       vecs[i].exp_rx, vecs[i].exp_mosi);
         prior = vecs[i].exp_mosi[0];
      end

      run_and_check("midxfer", 4'hA, 1'b0, 1'b1, 4'h5, model_rx(4'hA, 1'b0, prior),
                    wire_order(4'hA));
      prior = wire_order(4'hA) >> 0 & 1'b1;

      for (int i = 0; i < 16; i++) begin
         tx  = DW'($urandom_range(0, (1 << DW) - 1));
         slv = 1'($urandom_range(0, 1));
         run_and_check($sformatf("rnd%0d", i), tx, slv, 1'b0, '0, model_rx(tx, slv, prior),
                       wire_order(tx));
         prior = wire_order(tx) >> 0 & 1'b1;
      end

      // start held high: transfers repeat with one idle clock between them.
      @(negedge clk);
      use_slave = 1'b0; tx_data = 4'h9; start = 1'b1;
      cyc = 0; run = 0; rises = 0; ps = sclk;
      for (int i = 0; i < 3 * (LAT + 1) + 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (sclk && !ps) rises++;
         ps = sclk;
         if (CS) run++;
         else if (run > 0) begin
            runs.push_back(run);
            run = 0;
         end
         if (done) begin
            dq.push_back(cyc);
            check($sformatf("b2b_rx%0d", dq.size()), rx_data, 4'h9);
            if (dq.size() == 3) begin
               start = 1'b0;
               break;
            end
         end
      end
      check("b2b_done_count", dq.size(), 3);
      check("b2b_sclk_rises", rises, 3 * DW);
      check("b2b_cs_gaps", runs.size(), 2);
      if (dq.size() == 3) begin
         check("b2b_period0", dq[1] - dq[0], LAT + 1);
         check("b2b_period1", dq[2] - dq[1], LAT + 1);
      end
      if (runs.size() == 2) begin
         check("b2b_cs_high0", runs[0], 1);
         check("b2b_cs_high1", runs[1], 1);
      end
      @(negedge clk);

      // Reset during the high phase of bit 2 aborts the transfer without a done pulse.
      @(negedge clk);
      use_slave = 1'b0; tx_data = 4'hC; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      rises = 0; ps = sclk;
      for (int i = 0; i < LAT; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (sclk && !ps) rises++;
         ps = sclk;
         if (rises == 3 && sclk) break;
      end
      check("abort_reached_bit2", rises, 3);
      rst = 1'b1;
      #1;
      check("abort_cs", CS, 1'b1);
      check("abort_sclk", sclk, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0; cs_low = 0;
      for (int i = 0; i < 2 * LAT; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) dones++;
         if (!CS) cs_low++;
      end
      check("abort_no_done", dones, 0);
      check("abort_cs_stays_high", cs_low, 0);

      prior = 1'b0;
      run_and_check("post_abort", 4'h6, 1'b1, 1'b0, '0, model_rx(4'h6, 1'b1, prior),
                    wire_order(4'h6));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
